// File: rtl/box_filter_stream_if.sv
// box_filter_stream_if: raster pixel stream in, filtered pixel stream out
interface box_filter_stream_if #(parameter int CH = 3, parameter int CW = 8);
  logic in_valid, in_sof;
  logic [CH*CW-1:0] in_data;
  logic [1:0] mode;
  logic out_valid, out_sof, out_eol;
  logic [CH*CW-1:0] out_data;
  modport master(output in_valid, in_sof, in_data, mode, input out_valid, out_sof, out_eol, out_data);
  modport slave(input in_valid, in_sof, in_data, mode, output out_valid, out_sof, out_eol, out_data);
endinterface

// File: rtl/box_filter_stream.sv
// box_filter_stream: streaming 3x3 box-mean / 1-2-1 Gaussian / bypass filter over a raster stream.
// Define BOX_FILTER_ROUND_EN for round-half-up results instead of truncation.
module box_filter_stream #(
  parameter int CH = 3,
  parameter int CW = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic CLK,
  input logic RESET,
  box_filter_stream_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = CH * CW;
  localparam int SW = CW + 4;
  localparam logic [XW-1:0] LX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] LY = YW'(IMG_H - 1);
  typedef enum logic {IDLE, ACTIVE} st_t;
  st_t st;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic acc, cmp, v1, sof1, eol1;
  logic [1:0] m1;
  logic [PW-1:0] lb1 [IMG_W];
  logic [PW-1:0] lb2 [IMG_W];
  logic [PW-1:0] w [3][3];
  logic [PW-1:0] nw [3][3];
  logic [CH*SW-1:0] sel, s1;
  logic [PW-1:0] res;
  // an sof beat is pixel (0,0) regardless of where the counters are
  assign acc = bus.in_valid && (bus.in_sof || st == ACTIVE);
  assign cx = bus.in_sof ? '0 : x;
  assign cy = bus.in_sof ? '0 : y;
  assign cmp = acc && cx >= XW'(2) && cy >= YW'(2);
  // window rows: 0 = line y-2, 1 = line y-1, 2 = current line; column 2 is the newest
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = w[r][1];
      nw[r][1] = w[r][2];
    end
    nw[0][2] = lb2[cx];
    nw[1][2] = lb1[cx];
    nw[2][2] = bus.in_data;
  end
  always_ff @(posedge CLK)
    if (acc) begin
      lb1[cx] <= bus.in_data;
      lb2[cx] <= lb1[cx];
      w <= nw;
    end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SW-1:0] box, gau, s, box_q, gau_q;
    always_comb begin
      box = '0;
      gau = '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) begin
          box = box + SW'(nw[r][k][c*CW +: CW]);
          gau = gau + (SW'(nw[r][k][c*CW +: CW]) << (r % 2 + k % 2));
        end
    end
    assign sel[c*SW +: SW] = bus.mode == 2'd0 ? box : bus.mode == 2'd1 ? gau : SW'(nw[1][1][c*CW +: CW]);
    assign s = s1[c*SW +: SW];
`ifdef BOX_FILTER_ROUND_EN
    assign box_q = (s + SW'(4)) / SW'(9);
    assign gau_q = (s + SW'(8)) >> 4;
`else
    assign box_q = s / SW'(9);
    assign gau_q = s >> 4;
`endif
    assign res[c*CW +: CW] = m1 == 2'd0 ? box_q[CW-1:0] : m1 == 2'd1 ? gau_q[CW-1:0] : s[CW-1:0];
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      st <= IDLE;
      x <= '0;
      y <= '0;
      v1 <= 1'b0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      m1 <= '0;
      s1 <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof <= 1'b0;
      bus.out_eol <= 1'b0;
      bus.out_data <= '0;
    end else begin
      v1 <= cmp;
      sof1 <= cmp && cx == XW'(2) && cy == YW'(2);
      eol1 <= cmp && cx == LX;
      if (cmp) begin
        m1 <= bus.mode;
        s1 <= sel;
      end
      bus.out_valid <= v1;
      bus.out_sof <= v1 && sof1;
      bus.out_eol <= v1 && eol1;
      if (v1) bus.out_data <= res;
      if (acc) begin
        x <= cx == LX ? '0 : cx + XW'(1);
        y <= cx != LX ? cy : cy == LY ? '0 : cy + YW'(1);
        st <= cx == LX && cy == LY ? IDLE : ACTIVE;
      end
    end
endmodule

// File: tb/tb_box_filter_stream.sv
// tb_box_filter_stream: scoreboard bench for box_filter_stream on an 8x6 frame
module tb_box_filter_stream;
  localparam int W = 8;
  localparam int H = 6;
  typedef struct {
    logic [23:0] d;
    logic sof;
    logic eol;
    int due;
  } exp_t;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int got = 0;
  logic [23:0] first_d;
  logic [23:0] last = '0;
  logic [23:0] img [H][W];
  exp_t sb[$];
  box_filter_stream_if #(.CH(3), .CW(8)) bif ();
  box_filter_stream #(.CH(3), .CW(8), .IMG_W(W), .IMG_H(H)) dut (.CLK(CLK), .RESET(RESET), .bus(bif));
  always #5 CLK = ~CLK;

  function automatic logic [23:0] ref_px(int x, int y, logic [1:0] md);
    logic [23:0] r;
    int s, v;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          v = int'(img[y+dy][x+dx][c*8 +: 8]);
          s += md == 2'd0 ? v : v * (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
        end
`ifdef BOX_FILTER_ROUND_EN
      r[c*8 +: 8] = md == 2'd0 ? 8'((s + 4) / 9) : md == 2'd1 ? 8'((s + 8) / 16) : img[y][x][c*8 +: 8];
`else
      r[c*8 +: 8] = md == 2'd0 ? 8'(s / 9) : md == 2'd1 ? 8'(s / 16) : img[y][x][c*8 +: 8];
`endif
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    #1;
    cyc++;
    vectors++;
    if (!RESET) begin
      if ({bif.out_valid, bif.out_sof, bif.out_eol, bif.out_data} !== 27'd0)
        begin miscompares++; $display("FAIL reset_out: got v=%b s=%b e=%b d=%h, want all 0", bif.out_valid, bif.out_sof, bif.out_eol, bif.out_data); end
    end else if (bif.out_valid) begin
      if (got == 0) first_d = bif.out_data;
      got++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out: cycle %0d d=%h, want no output", cyc, bif.out_data);
      end else begin
        e = sb.pop_front();
        if ({bif.out_data, bif.out_sof, bif.out_eol} !== {e.d, e.sof, e.eol} || cyc != e.due)
          begin miscompares++; $display("FAIL out_pixel: cycle %0d d=%h s=%b e=%b, want cycle %0d d=%h s=%b e=%b", cyc, bif.out_data, bif.out_sof, bif.out_eol, e.due, e.d, e.sof, e.eol); end
      end
    end else if ({bif.out_sof, bif.out_eol, bif.out_data} !== {2'b00, last}) begin
      miscompares++;
      $display("FAIL idle_hold: s=%b e=%b d=%h, want 0 0 %h", bif.out_sof, bif.out_eol, bif.out_data, last);
    end
    last = bif.out_data;
  end

  task automatic drive_frame(input logic [1:0] md, input int gap, input bit sof_en, input bit chk, input int nbeats);
    int n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (n < nbeats) begin
          while (gap > 0 && $urandom_range(99) < gap) begin
            @(negedge CLK);
            bif.in_valid = 1'b0;
            bif.in_data = 24'($urandom);
          end
          @(negedge CLK);
          bif.in_valid = 1'b1;
          bif.in_sof = sof_en && x == 0 && y == 0;
          bif.in_data = img[y][x];
          bif.mode = md;
          if (chk && x >= 2 && y >= 2)
            sb.push_back('{ref_px(x - 1, y - 1, md), x == 2 && y == 2, x == W - 1, cyc + 2});
          n++;
        end
      end
    @(negedge CLK);
    bif.in_valid = 1'b0;
    bif.in_sof = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int want);
    repeat (4) @(negedge CLK);
    vectors++;
    if (got !== want || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_count: got %0d outputs with %0d pending, want %0d with 0 pending", name, got, sb.size(), want);
      sb.delete();
    end
  endtask

  task automatic fill(input bit kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = kind ? 24'(x + 8 * y) : 24'h406080;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({bif.out_valid, bif.out_sof, bif.out_eol, bif.out_data} !== 27'd0)
      begin miscompares++; $display("FAIL test_reset: got %b/%b/%b/%h, want 0/0/0/0", bif.out_valid, bif.out_sof, bif.out_eol, bif.out_data); end
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_const;
    fill(1'b0);
    got = 0;
    drive_frame(2'd0, 0, 1'b1, 1'b1, W * H);
    finish_frame("const", 24);
  endtask

  task automatic test_impulse(input logic [1:0] md);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = (x == 3 && y == 3) ? 24'hFFFFFF : 24'h0;
    got = 0;
    drive_frame(md, 0, 1'b1, 1'b1, W * H);
    finish_frame(md == 2'd0 ? "impulse_box" : "impulse_gauss", 24);
  endtask

  task automatic test_ramp_bypass;
    fill(1'b1);
    got = 0;
    drive_frame(2'd2, 0, 1'b1, 1'b1, W * H);
    finish_frame("ramp", 24);
    vectors++;
    if (first_d !== 24'd9) begin miscompares++; $display("FAIL ramp_first: got %h, want 000009", first_d); end
    got = 0;
    drive_frame(2'd3, 0, 1'b1, 1'b1, W * H);
    finish_frame("ramp_mode3", 24);
  endtask

  task automatic test_gaps;
    fill(1'b0);
    got = 0;
    drive_frame(2'd0, 50, 1'b1, 1'b1, W * H);
    finish_frame("gaps", 24);
    fill(1'b1);
    got = 0;
    drive_frame(2'd1, 50, 1'b1, 1'b1, W * H);
    finish_frame("gaps_gauss", 24);
  endtask

  task automatic test_mid_reset;
    int r;
    fill(1'b1);
    got = 0;
    drive_frame(2'd0, 0, 1'b1, 1'b1, 3 * W + 5);
    RESET = 1'b0;
    r = cyc;
    while (sb.size() > 0 && sb[$].due > r) void'(sb.pop_back());
    @(negedge CLK);
    RESET = 1'b1;
    got = 0;
    drive_frame(2'd0, 0, 1'b0, 1'b0, W * H);
    finish_frame("no_sof", 0);
    fill(1'b0);
    got = 0;
    drive_frame(2'd0, 0, 1'b1, 1'b1, W * H);
    finish_frame("after_reset", 24);
  endtask

  initial begin
    bif.in_valid = 1'b0;
    bif.in_sof = 1'b0;
    bif.in_data = '0;
    bif.mode = '0;
    test_reset();
    test_const();
    test_impulse(2'd0);
    test_impulse(2'd1);
    test_ramp_bypass();
    test_gaps();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
